// File: rtl/demux_1to3_pkg.sv
// Shared encodings and constants for the 1-to-3 demultiplexer.
// The optional DEMUX_1TO3_CNT_EN build adds per-port delivery counters of width CNT_W.
package demux_1to3_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_P0 = 2'b00;
    localparam sel_t SEL_P1 = 2'b01;
    localparam sel_t SEL_P2 = 2'b10;

    localparam int CNT_W = 16;

    // 2'b11 folds onto port2 so every select value addresses exactly one port.
    function automatic logic [2:0] port_hit(input sel_t sel);
        logic [2:0] hit;
        hit = 3'b100;
        case (sel)
            SEL_P0:  hit = 3'b001;
            SEL_P1:  hit = 3'b010;
            default: hit = 3'b100;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: data register plus full flag, refillable on the same edge it drains.
// With DEMUX_1TO3_CNT_EN defined it also counts its own transfers out (wrapping).
module demux_slot
    import demux_1to3_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] wdata,
    input  logic             take,
    output logic [width-1:0] data,
    output logic             full,
    output logic             open
`ifdef DEMUX_1TO3_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic drain;

    assign drain = full && take;
    assign open  = !full || take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (push) begin
            full <= 1'b1;
            data <= wdata;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

`ifdef DEMUX_1TO3_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_1to3.sv
// 1-to-3 valid/ready demultiplexer: select decode and upstream ready over three demux_slot buffers.
// Define DEMUX_1TO3_CNT_EN to expose the per-port 16-bit delivery counters cnt0_o..cnt2_o.
module demux_1to3
    import demux_1to3_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic [1:0]      select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic [size-1:0] data1_o,
    output logic [size-1:0] data2_o,
    output logic            valid0_o,
    output logic            valid1_o,
    output logic            valid2_o,
    input  logic            ready0_i,
    input  logic            ready1_i,
    input  logic            ready2_i
`ifdef DEMUX_1TO3_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o,
    output logic [CNT_W-1:0] cnt2_o
`endif
);

    logic [2:0] hit;
    logic [2:0] open;
    logic [2:0] push;
    logic       accept;

    assign hit = port_hit(select_i);

    // Gating with rst_i keeps ready_o low throughout reset regardless of slot state.
    assign ready_o = rst_i && |(hit & open);
    assign accept  = valid_i && ready_o;
    assign push    = hit & {3{accept}};

    demux_slot #(.width(size)) u_slot0 (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (push[0]),
        .wdata (data_i),
        .take  (ready0_i),
        .data  (data0_o),
        .full  (valid0_o),
        .open  (open[0])
`ifdef DEMUX_1TO3_CNT_EN
        ,
        .cnt   (cnt0_o)
`endif
    );

    demux_slot #(.width(size)) u_slot1 (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (push[1]),
        .wdata (data_i),
        .take  (ready1_i),
        .data  (data1_o),
        .full  (valid1_o),
        .open  (open[1])
`ifdef DEMUX_1TO3_CNT_EN
        ,
        .cnt   (cnt1_o)
`endif
    );

    demux_slot #(.width(size)) u_slot2 (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (push[2]),
        .wdata (data_i),
        .take  (ready2_i),
        .data  (data2_o),
        .full  (valid2_o),
        .open  (open[2])
`ifdef DEMUX_1TO3_CNT_EN
        ,
        .cnt   (cnt2_o)
`endif
    );

endmodule

// File: tb/tb_demux_1to3.sv
// Directed bench for demux_1to3: reset, routing, backpressure, streaming, mid-run reset.
// Counter-wrap vectors run only when DEMUX_1TO3_CNT_EN is defined.
module tb_demux_1to3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic [1:0]  select_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data0_o, data1_o, data2_o;
    logic        valid0_o, valid1_o, valid2_o;
    logic        ready0_i, ready1_i, ready2_i;
`ifdef DEMUX_1TO3_CNT_EN
    logic [15:0] cnt0_o, cnt1_o, cnt2_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    demux_1to3 #(.size(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .data1_o  (data1_o),
        .data2_o  (data2_o),
        .valid0_o (valid0_o),
        .valid1_o (valid1_o),
        .valid2_o (valid2_o),
        .ready0_i (ready0_i),
        .ready1_i (ready1_i),
        .ready2_i (ready2_i)
`ifdef DEMUX_1TO3_CNT_EN
        ,
        .cnt0_o   (cnt0_o),
        .cnt1_o   (cnt1_o),
        .cnt2_o   (cnt2_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d);
        valid_i  = v;
        select_i = sel;
        data_i   = d;
    endtask

    int seen1;

    initial begin
        rst_i = 1'b0;
        ready0_i = 1'b1; ready1_i = 1'b1; ready2_i = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_0001);

        // reset held with valid_i high
        repeat (3) @(negedge clk_i);
        check("rst_ready", ready_o, 0);
        check("rst_valid", {valid2_o, valid1_o, valid0_o}, 0);
        check("rst_data0", data0_o, 0);
        check("rst_data2", data2_o, 0);
        rst_i = 1'b1;
        #1 check("rel_ready", ready_o, 1);
        @(negedge clk_i);
        check("rel_valid0", valid0_o, 1);
        check("rel_data0", data0_o, 32'h0000_0001);

        // routing: select 00 then 11
        drive(1'b1, 2'b00, 32'hA5A5_0001);
        @(negedge clk_i);
        check("rt_valid0", valid0_o, 1);
        check("rt_data0", data0_o, 32'hA5A5_0001);
        drive(1'b1, 2'b11, 32'hA5A5_0002);
        @(negedge clk_i);
        check("rt_valid2", valid2_o, 1);
        check("rt_data2", data2_o, 32'hA5A5_0002);
        check("rt_valid0_drained", valid0_o, 0);
        check("rt_valid1_idle", valid1_o, 0);
        drive(1'b0, 2'b00, 32'h0);
        @(negedge clk_i);
        check("rt_valid2_drained", valid2_o, 0);

        // backpressure on port1
        ready1_i = 1'b0;
        drive(1'b1, 2'b01, 32'h0000_1111);
        @(negedge clk_i);
        check("bp_valid1", valid1_o, 1);
        check("bp_data1", data1_o, 32'h0000_1111);
        drive(1'b1, 2'b01, 32'h0000_2222);
        #1 check("bp_ready_low", ready_o, 0);
        @(negedge clk_i);
        check("bp_data1_stable", data1_o, 32'h0000_1111);
        check("bp_valid1_held", valid1_o, 1);
        drive(1'b1, 2'b00, 32'h0000_0005);
        #1 check("bp_ready_p0", ready_o, 1);
        @(negedge clk_i);
        check("bp_data0", data0_o, 32'h0000_0005);
        check("bp_valid0", valid0_o, 1);
        check("bp_data1_still", data1_o, 32'h0000_1111);
        drive(1'b0, 2'b01, 32'hFFFF_FFFF);
        ready1_i = 1'b1;
        @(negedge clk_i);
        check("bp_valid1_drained", valid1_o, 0);
        check("bp_valid0_drained", valid0_o, 0);

        // streaming 8 words into port2
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b10, 32'h0000_0100 + i);
            #1 check("st_ready", ready_o, 1);
            if (i > 0) begin
                check("st_valid2", valid2_o, 1);
                check("st_data2", data2_o, 32'h0000_0100 + i - 1);
            end
            @(negedge clk_i);
        end
        drive(1'b0, 2'b10, 32'h0);
        check("st_valid2_last", valid2_o, 1);
        check("st_data2_last", data2_o, 32'h0000_0107);
        @(negedge clk_i);
        check("st_valid2_end", valid2_o, 0);

        // valid_i low: select/data are don't-care
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i[1:0], 32'hC0DE_0000 + i);
            @(negedge clk_i);
            check("idle_valid", {valid2_o, valid1_o, valid0_o}, 0);
        end

        // reset with port1 holding DEAD
        ready1_i = 1'b0;
        drive(1'b1, 2'b01, 32'h0000_DEAD);
        @(negedge clk_i);
        check("mr_valid1", valid1_o, 1);
        check("mr_data1", data1_o, 32'h0000_DEAD);
        drive(1'b0, 2'b00, 32'h0);
        #2 rst_i = 1'b0;
        #1;
        check("mr_valid1_clr", valid1_o, 0);
        check("mr_data1_clr", data1_o, 0);
        check("mr_ready", ready_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        ready1_i = 1'b1;
        seen1 = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (valid1_o) seen1++;
        end
        check("mr_no_delivery", seen1, 0);

`ifdef DEMUX_1TO3_CNT_EN
        check("cnt0_reset", {16'h0, cnt0_o}, 0);
        ready0_i = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_00AA);
        repeat (65537) @(negedge clk_i);
        drive(1'b0, 2'b00, 32'h0);
        @(negedge clk_i);
        check("cnt0_wrap", {16'h0, cnt0_o}, 1);
        check("cnt1_zero", {16'h0, cnt1_o}, 0);
        check("cnt2_zero", {16'h0, cnt2_o}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1to3.md
DEMUX_1TO3 -- requirements
Module: demux_1to3

Interface
REQ-001 Parameter: size, default 32, width of the data path.
REQ-002 The block SHALL have the ports below; one clock, and reset asynchronous and active-low.
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  asynchronous active-low reset.
- data_i  input  size  upstream data word.
- select_i  input  2  destination: 00->port0, 01->port1, 10/11->port2.
- valid_i  input  1  upstream word present.
- ready_o  output  1  word accepted this cycle when high with valid_i.
- dataN_o  output  size  port N data (N=0,1,2).
- validN_o  output  1  port N holds a word.
- readyN_i  input  1  port N consumer takes word.

Function
REQ-003 Each port SHALL own a one-entry buffer (data register plus full flag); validN_o equals the full flag and dataN_o equals the data register.
REQ-004 select_i decoding SHALL map 2'b11 to port2, identical to 2'b10.
REQ-005 ready_o SHALL be combinational: high when the selected port is empty, or full with its readyN_i high.
REQ-006 A transfer in SHALL occur on a rising edge with valid_i and ready_o high; the word SHALL appear on the selected dataN_o with validN_o high from the next cycle, giving one-cycle latency.
REQ-007 A transfer out SHALL occur on a rising edge with validN_o and readyN_i high; that port SHALL empty unless it is refilled on the same edge.
REQ-008 Simultaneous transfer out and transfer in on the same port SHALL replace the data and keep validN_o high, sustaining one word per cycle per port.
REQ-009 Ports not addressed by select_i SHALL be unaffected by upstream traffic; a stalled port SHALL NOT block words routed to other ports.
REQ-010 While validN_o is high and readyN_i is low, dataN_o SHALL stay stable.
REQ-011 select_i and data_i SHALL be don't-care when valid_i is low; no state SHALL change.
REQ-012 The block SHALL be lossless and order-preserving per port.

Reset
REQ-013 While rst_i is low, all validN_o SHALL be 0, all dataN_o SHALL be 0, and ready_o SHALL be 0 regardless of other inputs.
REQ-014 Reset asserted mid-operation SHALL discard buffered words with no output transfer; the first acceptance SHALL occur on the first edge after rst_i rises.

Configuration
REQ-015 With macro DEMUX_1TO3_CNT_EN defined, the block SHALL add outputs cnt0_o, cnt1_o and cnt2_o, each 16 bits wide.
- Each counter increments on its port's transfer out.
- Each counter wraps from 16'hFFFF to 0.
- Each counter resets to 0.
REQ-016 Without DEMUX_1TO3_CNT_EN, the counter outputs and registers SHALL NOT exist; all other behaviour is identical.

Structure
REQ-017 A shared package SHALL hold the select encodings (SEL_P0=2'b00, SEL_P1=2'b01, SEL_P2=2'b10) and the counter width constant (16).
REQ-018 The one-entry buffer SHALL be a sub-module demux_slot, instantiated three times; demux_1to3 holds only the decode and ready_o logic.

Verification
REQ-019 Reset behaviour: hold rst_i low with valid_i=1 -> ready_o=0 and all validN_o=0; release -> accepted on the next edge.
REQ-020 Routing: send 32'hA5A5_0001 with select 00, then 32'hA5A5_0002 with select 11, all readyN_i=1 -> dataN_o shows the words one cycle after acceptance on port0 and port2 respectively.
REQ-021 Backpressure: ready1_i=0 with port1 full, valid_i=1, select 01 -> ready_o=0 and data1_o stable; then select 00 with 32'h5 -> accepted onto port0.
REQ-022 Streaming: 8 back-to-back words to port2 with ready2_i=1 -> ready_o high every cycle and 8 transfers out in order, no bubbles.
REQ-023 Reset mid-operation: assert rst_i with port1 holding 32'hDEAD -> valid1_o=0 and data1_o=0 immediately; nothing is delivered after release.
REQ-024 Counter wrap (DEMUX_1TO3_CNT_EN defined): 65537 transfers out of port0 -> cnt0_o=1; cnt1_o and cnt2_o stay 0.
